// File: rtl/mnacidpro_seq_pkg.sv
// Shared types and constants for the mnacidpro protocol sequencer:
// FSM states, valve bit positions, per-step open masks and pump phases.
package mnacidpro_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOAD,
    ST_LYSIS,
    ST_CAPTURE,
    ST_WASH,
    ST_ELUTE,
    ST_COLLECT,
    ST_FLUSH,
    ST_ABORT
  } state_t;

  localparam int NUM_VALVES = 11;
  localparam int PUMP_W     = 3;
  localparam int FLUSH_W    = NUM_VALVES + PUMP_W;

  localparam int V_LYSIS     = 0;
  localparam int V_WASH      = 1;
  localparam int V_ELUTE     = 2;
  localparam int V_DEAD_END  = 3;
  localparam int V_VERTICAL  = 4;
  localparam int V_HORIZ     = 5;
  localparam int V_WASTE     = 6;
  localparam int V_BEAD      = 7;
  localparam int V_LOOP_EXIT = 8;
  localparam int V_BEAD_TRAP = 9;
  localparam int V_COLLECT   = 10;

  // A set bit means the valve is closed; each mask clears only its open valves.
  localparam logic [NUM_VALVES-1:0] ALL_CLOSED = 11'h7FF;
  localparam logic [NUM_VALVES-1:0] MASK_LOAD = ALL_CLOSED &
    ~((11'd1 << V_BEAD) | (11'd1 << V_VERTICAL) | (11'd1 << V_BEAD_TRAP) | (11'd1 << V_WASTE));
  localparam logic [NUM_VALVES-1:0] MASK_LYSIS = ALL_CLOSED &
    ~((11'd1 << V_LYSIS) | (11'd1 << V_DEAD_END) | (11'd1 << V_LOOP_EXIT));
  localparam logic [NUM_VALVES-1:0] MASK_CAPTURE = ALL_CLOSED &
    ~((11'd1 << V_LOOP_EXIT) | (11'd1 << V_BEAD_TRAP) | (11'd1 << V_WASTE));
  localparam logic [NUM_VALVES-1:0] MASK_WASH = ALL_CLOSED &
    ~((11'd1 << V_WASH) | (11'd1 << V_HORIZ) | (11'd1 << V_BEAD_TRAP) | (11'd1 << V_WASTE));
  localparam logic [NUM_VALVES-1:0] MASK_ELUTE = ALL_CLOSED &
    ~((11'd1 << V_ELUTE) | (11'd1 << V_HORIZ) | (11'd1 << V_BEAD_TRAP) | (11'd1 << V_DEAD_END));
  localparam logic [NUM_VALVES-1:0] MASK_COLLECT = ALL_CLOSED &
    ~((11'd1 << V_ELUTE) | (11'd1 << V_BEAD_TRAP) | (11'd1 << V_COLLECT));

  localparam logic [FLUSH_W-1:0] FLUSH_ALL = 14'h3FFF;

  localparam logic [PUMP_W-1:0] PUMP_OFF = 3'b111;
  localparam logic [PUMP_W-1:0] PUMP_PH0 = 3'b110;
  localparam logic [PUMP_W-1:0] PUMP_PH1 = 3'b101;
  localparam logic [PUMP_W-1:0] PUMP_PH2 = 3'b011;

  function automatic logic [NUM_VALVES-1:0] state_mask(state_t s);
    case (s)
      ST_LOAD:    state_mask = MASK_LOAD;
      ST_LYSIS:   state_mask = MASK_LYSIS;
      ST_CAPTURE: state_mask = MASK_CAPTURE;
      ST_WASH:    state_mask = MASK_WASH;
      ST_ELUTE:   state_mask = MASK_ELUTE;
      ST_COLLECT: state_mask = MASK_COLLECT;
      default:    state_mask = ALL_CLOSED;
    endcase
  endfunction

  function automatic logic pump_active(state_t s);
    pump_active = (s == ST_LOAD) || (s == ST_LYSIS) || (s == ST_CAPTURE) ||
                  (s == ST_WASH) || (s == ST_ELUTE) || (s == ST_COLLECT);
  endfunction

endpackage

// File: rtl/mnacidpro_seq_if.sv
// Host-side command and solenoid-driver signals of the sequencer.
// master = host/driver side, slave = sequencer.
interface mnacidpro_seq_if
  import mnacidpro_seq_pkg::*;
#(
  parameter int SIZE = 3
);
  localparam int SEL_W = $clog2(SIZE);

  logic                  start;
  logic                  abort;
  logic                  hold;
  logic [NUM_VALVES-1:0] valve_ctrl;
  logic [PUMP_W-1:0]     pump;
  logic [FLUSH_W-1:0]    flush;
  logic [SEL_W-1:0]      collect_sel;
  logic                  busy;
  logic                  done;
  logic                  aborted;

  modport master (
    output start, abort, hold,
    input  valve_ctrl, pump, flush, collect_sel, busy, done, aborted
  );

  modport slave (
    input  start, abort, hold,
    output valve_ctrl, pump, flush, collect_sel, busy, done, aborted
  );
endinterface

// File: rtl/mnacidpro_pump_phaser.sv
// Peristaltic pump driver: divides clk by PUMP_DIV and rotates 110->101->011.
// en=0 parks the pump closed, clr restarts at 110, freeze holds divider and phase.
module mnacidpro_pump_phaser
  import mnacidpro_seq_pkg::*;
#(
  parameter int PUMP_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              freeze,
  output logic [PUMP_W-1:0] phase
);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(PUMP_DIV - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0]  div_reg;
  logic [PUMP_W-1:0] phase_reg;
  logic [PUMP_W-1:0] phase_next;

  always_comb begin
    phase_next = PUMP_PH0;
    case (phase_reg)
      PUMP_PH0: phase_next = PUMP_PH1;
      PUMP_PH1: phase_next = PUMP_PH2;
      default:  phase_next = PUMP_PH0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_reg   <= '0;
      phase_reg <= PUMP_OFF;
    end else if (clr) begin
      div_reg   <= '0;
      phase_reg <= PUMP_PH0;
    end else if (!freeze) begin
      if (div_reg == DIV_LAST) begin
        div_reg   <= '0;
        phase_reg <= phase_next;
      end else begin
        div_reg <= div_reg + ONE;
      end
    end
  end

  assign phase = phase_reg;
endmodule

// File: rtl/mnacidpro_seq_ctrl.sv
// Protocol sequencer: load, lysis, capture, washes, elute, multi-outlet collect, flush,
// with an all-closed settle gap before every valve-mask change.
module mnacidpro_seq_ctrl
  import mnacidpro_seq_pkg::*;
#(
  parameter int SIZE      = 3,
  parameter int CNT_W     = 16,
  parameter int PUMP_DIV  = 4,
  parameter int T_LOAD    = 64,
  parameter int T_LYSIS   = 128,
  parameter int T_CAPTURE = 96,
  parameter int T_WASH    = 32,
  parameter int WASH_REPS = 2,
  parameter int T_ELUTE   = 64,
  parameter int T_COLLECT = 16,
  parameter int T_FLUSH   = 8,
  parameter int T_SETTLE  = 2
) (
  input  logic            clk,
  input  logic            rst,
  mnacidpro_seq_if.slave  bus
);
  localparam int SEL_W = $clog2(SIZE);
  localparam int WC_W  = (WASH_REPS > 1) ? $clog2(WASH_REPS) : 1;
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_SETTLE - 1);
  localparam logic [WC_W-1:0]  WASH_LAST   = WC_W'(WASH_REPS - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(SIZE - 1);

  state_t                state_reg, state_next;
  state_t                target_reg, target_next;
  logic [CNT_W-1:0]      dwell_reg, dwell_next;
  logic [WC_W-1:0]       wash_reg, wash_next;
  logic [SEL_W-1:0]      coll_reg, coll_next;
  logic [SEL_W-1:0]      sel_reg, sel_next;
  logic [NUM_VALVES-1:0] valve_reg, valve_next;
  logic [FLUSH_W-1:0]    flush_reg, flush_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  aborted_reg, aborted_next;
  logic [PUMP_W-1:0]     pump_phase;

  function automatic logic [CNT_W-1:0] dwell_of(state_t s);
    case (s)
      ST_LOAD:    dwell_of = CNT_W'(T_LOAD - 1);
      ST_LYSIS:   dwell_of = CNT_W'(T_LYSIS - 1);
      ST_CAPTURE: dwell_of = CNT_W'(T_CAPTURE - 1);
      ST_WASH:    dwell_of = CNT_W'(T_WASH - 1);
      ST_ELUTE:   dwell_of = CNT_W'(T_ELUTE - 1);
      ST_COLLECT: dwell_of = CNT_W'(T_COLLECT - 1);
      ST_FLUSH:   dwell_of = CNT_W'(T_FLUSH - 1);
      default:    dwell_of = SETTLE_LAST;
    endcase
  endfunction

  always_comb begin
    state_next   = state_reg;
    target_next  = target_reg;
    dwell_next   = dwell_reg;
    wash_next    = wash_reg;
    coll_next    = coll_reg;
    sel_next     = sel_reg;
    valve_next   = valve_reg;
    flush_next   = flush_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    aborted_next = 1'b0;

    if (bus.abort && state_reg != ST_IDLE && state_reg != ST_ABORT) begin
      state_next = ST_ABORT;
      dwell_next = SETTLE_LAST;
      valve_next = ALL_CLOSED;
      flush_next = '0;
    end else if (bus.hold && !bus.abort && state_reg != ST_IDLE) begin
      state_next = state_reg;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_next  = ST_SETTLE;
            target_next = ST_LOAD;
            dwell_next  = SETTLE_LAST;
            wash_next   = '0;
            coll_next   = '0;
            sel_next    = '0;
            valve_next  = ALL_CLOSED;
            busy_next   = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (dwell_reg == '0) begin
            state_next = target_reg;
            dwell_next = dwell_of(target_reg);
            valve_next = state_mask(target_reg);
            flush_next = (target_reg == ST_FLUSH) ? FLUSH_ALL : '0;
            if (target_reg == ST_COLLECT) sel_next = coll_reg;
          end else begin
            dwell_next = dwell_reg - ONE;
          end
        end
        ST_FLUSH, ST_ABORT: begin
          if (dwell_reg == '0) begin
            state_next   = ST_IDLE;
            done_next    = (state_reg == ST_FLUSH);
            aborted_next = (state_reg == ST_ABORT);
            busy_next    = 1'b0;
            flush_next   = '0;
            sel_next     = '0;
          end else begin
            dwell_next = dwell_reg - ONE;
          end
        end
        default: begin
          if (dwell_reg == '0) begin
            state_next = ST_SETTLE;
            dwell_next = SETTLE_LAST;
            valve_next = ALL_CLOSED;
            // Loop counters only advance while below their limit, so they never wrap.
            case (state_reg)
              ST_LOAD:    target_next = ST_LYSIS;
              ST_LYSIS:   target_next = ST_CAPTURE;
              ST_CAPTURE: target_next = ST_WASH;
              ST_WASH: begin
                if (wash_reg == WASH_LAST) begin
                  target_next = ST_ELUTE;
                end else begin
                  target_next = ST_WASH;
                  wash_next   = wash_reg + WC_W'(1);
                end
              end
              ST_ELUTE:   target_next = ST_COLLECT;
              ST_COLLECT: begin
                if (coll_reg == SEL_LAST) begin
                  target_next = ST_FLUSH;
                end else begin
                  target_next = ST_COLLECT;
                  coll_next   = coll_reg + SEL_W'(1);
                end
              end
              default:    target_next = ST_FLUSH;
            endcase
          end else begin
            dwell_next = dwell_reg - ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      target_reg  <= ST_IDLE;
      dwell_reg   <= '0;
      wash_reg    <= '0;
      coll_reg    <= '0;
      sel_reg     <= '0;
      valve_reg   <= ALL_CLOSED;
      flush_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      target_reg  <= target_next;
      dwell_reg   <= dwell_next;
      wash_reg    <= wash_next;
      coll_reg    <= coll_next;
      sel_reg     <= sel_next;
      valve_reg   <= valve_next;
      flush_reg   <= flush_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
    end
  end

  // Every working-state entry is a state change, which restarts the pump at 110.
  mnacidpro_pump_phaser #(
    .PUMP_DIV (PUMP_DIV),
    .CNT_W    (CNT_W)
  ) u_pump (
    .clk    (clk),
    .rst    (rst),
    .en     (pump_active(state_next)),
    .clr    (state_next != state_reg),
    .freeze (bus.hold),
    .phase  (pump_phase)
  );

  assign bus.valve_ctrl  = valve_reg;
  assign bus.pump        = pump_phase;
  assign bus.flush       = flush_reg;
  assign bus.collect_sel = sel_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.aborted     = aborted_reg;
endmodule

// File: tb/tb_mnacidpro_seq_ctrl.sv
// Scoreboard bench: stimulus queues the expected output segments of each run, and a
// negedge monitor closes a segment whenever the output tuple changes and checks it.
module tb_mnacidpro_seq_ctrl;

  typedef struct {
    logic [10:0] valve;
    logic [13:0] flush;
    logic        busy;
    logic [1:0]  sel;
    logic        done;
    logic        aborted;
    int          len;
    logic [11:0] pseq;
    int          pchg;
  } seg_t;

  // Hand-computed masks (1 = closed); bits: 0 lysis 1 wash 2 elute 3 dead_end 4 vertical
  // 5 horiz 6 waste 7 bead 8 loop_exit 9 bead_trap 10 collect.
  localparam logic [10:0] M_CLOSED  = 11'h7FF;
  localparam logic [10:0] M_LOAD    = 11'h52F;
  localparam logic [10:0] M_LYSIS   = 11'h6F6;
  localparam logic [10:0] M_CAPTURE = 11'h4BF;
  localparam logic [10:0] M_WASH    = 11'h59D;
  localparam logic [10:0] M_ELUTE   = 11'h5D3;
  localparam logic [10:0] M_COLLECT = 11'h1FB;
  localparam logic [11:0] PSEQ_OFF  = 12'h007;
  localparam logic [11:0] PSEQ_RUN  = 12'hD5E;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mnacidpro_seq_if #(.SIZE(3)) bus ();

  mnacidpro_seq_ctrl #(.SIZE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   seg_no  = 0;
  seg_t exp_q[$];

  seg_t        cur;
  logic        tracking = 1'b0;
  logic [2:0]  prev_pump;
  int          pn;

  task automatic push(input logic [10:0] v, input logic [13:0] f, input logic b,
                      input logic [1:0] s, input logic d, input logic a, input int len,
                      input logic [11:0] pseq, input int pchg);
    seg_t e;
    e.valve = v; e.flush = f; e.busy = b; e.sel = s; e.done = d; e.aborted = a;
    e.len = len; e.pseq = pseq; e.pchg = pchg;
    exp_q.push_back(e);
  endtask

  task automatic push_settle(input logic [1:0] s);
    push(M_CLOSED, 14'h0, 1'b1, s, 1'b0, 1'b0, 2, PSEQ_OFF, 0);
  endtask

  task automatic push_work(input logic [10:0] v, input logic [1:0] s, input int len, input int pchg);
    push(v, 14'h0, 1'b1, s, 1'b0, 1'b0, len, PSEQ_RUN, pchg);
  endtask

  task automatic push_front(input int lysis_len);
    push(M_CLOSED, 14'h0, 1'b0, 2'd0, 1'b0, 1'b0, -1, PSEQ_OFF, 0);
    push_settle(2'd0);
    push_work(M_LOAD, 2'd0, 64, 15);
    push_settle(2'd0);
    push_work(M_LYSIS, 2'd0, lysis_len, 31);
    push_settle(2'd0);
    push_work(M_CAPTURE, 2'd0, 96, 23);
    push_settle(2'd0);
    push_work(M_WASH, 2'd0, 32, 7);
    push_settle(2'd0);
    push_work(M_WASH, 2'd0, 32, 7);
    push_settle(2'd0);
  endtask

  task automatic push_tail();
    push_work(M_ELUTE, 2'd0, 64, 15);
    push_settle(2'd0);
    for (int k = 0; k < 3; k++) begin
      push_work(M_COLLECT, 2'(k), 16, 3);
      push_settle(2'(k));
    end
    push(M_CLOSED, 14'h3FFF, 1'b1, 2'd2, 1'b0, 1'b0, 8, PSEQ_OFF, 0);
    push(M_CLOSED, 14'h0, 1'b0, 2'd0, 1'b1, 1'b0, 1, PSEQ_OFF, 0);
  endtask

  task automatic check_seg(input seg_t a);
    seg_t e;
    n_tests++;
    seg_no++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL seg%0d unexpected: got valve=%h flush=%h busy=%b sel=%0d done=%b aborted=%b len=%0d, required none",
               seg_no, a.valve, a.flush, a.busy, a.sel, a.done, a.aborted, a.len);
    end else begin
      e = exp_q.pop_front();
      if (a.valve !== e.valve || a.flush !== e.flush || a.busy !== e.busy || a.sel !== e.sel ||
          a.done !== e.done || a.aborted !== e.aborted || (e.len >= 0 && a.len != e.len) ||
          a.pseq !== e.pseq || a.pchg != e.pchg) begin
        n_fail++;
        $display("FAIL seg%0d: got valve=%h flush=%h busy=%b sel=%0d done=%b aborted=%b len=%0d pseq=%h pchg=%0d, required valve=%h flush=%h busy=%b sel=%0d done=%b aborted=%b len=%0d pseq=%h pchg=%0d",
                 seg_no, a.valve, a.flush, a.busy, a.sel, a.done, a.aborted, a.len, a.pseq, a.pchg,
                 e.valve, e.flush, e.busy, e.sel, e.done, e.aborted, e.len, e.pseq, e.pchg);
      end
    end
  endtask

  // Monitor: one segment = a run of cycles with identical valve/flush/busy/sel/done/aborted.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        tracking = 1'b0;
      end else if (!tracking || bus.valve_ctrl !== cur.valve || bus.flush !== cur.flush ||
                   bus.busy !== cur.busy || bus.collect_sel !== cur.sel ||
                   bus.done !== cur.done || bus.aborted !== cur.aborted) begin
        if (tracking) check_seg(cur);
        cur.valve = bus.valve_ctrl; cur.flush = bus.flush; cur.busy = bus.busy;
        cur.sel = bus.collect_sel; cur.done = bus.done; cur.aborted = bus.aborted;
        cur.len = 1; cur.pseq = {9'b0, bus.pump}; cur.pchg = 0;
        pn = 1; prev_pump = bus.pump; tracking = 1'b1;
      end else begin
        cur.len++;
        if (bus.pump !== prev_pump) begin
          cur.pchg++;
          if (pn < 4) begin
            cur.pseq = {cur.pseq[8:0], bus.pump};
            pn++;
          end
          prev_pump = bus.pump;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valve(input logic [10:0] v, input string what);
    int k = 0;
    while (bus.valve_ctrl !== v && k < 2000) begin
      tick();
      k++;
    end
    n_tests++;
    if (bus.valve_ctrl !== v) begin
      n_fail++;
      $display("FAIL wait_%s: valve=%h after %0d cycles, required %h", what, bus.valve_ctrl, k, v);
    end
  endtask

  task automatic drain(input string what);
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      tick();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d expected segments never seen, required 0", what, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outputs(input string what, input logic [10:0] v, input logic [2:0] p,
                               input logic [13:0] f, input logic [1:0] s, input logic b,
                               input logic d, input logic a);
    n_tests++;
    if (bus.valve_ctrl !== v || bus.pump !== p || bus.flush !== f || bus.collect_sel !== s ||
        bus.busy !== b || bus.done !== d || bus.aborted !== a) begin
      n_fail++;
      $display("FAIL %s: got valve=%h pump=%b flush=%h sel=%0d busy=%b done=%b aborted=%b, required valve=%h pump=%b flush=%h sel=%0d busy=%b done=%b aborted=%b",
               what, bus.valve_ctrl, bus.pump, bus.flush, bus.collect_sel, bus.busy, bus.done,
               bus.aborted, v, p, f, s, b, d, a);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    rst = 1'b1;
    tick();
    check_outputs("reset", M_CLOSED, 3'b111, 14'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // start and abort together in IDLE: nothing may start
    push(M_CLOSED, 14'h0, 1'b0, 2'd0, 1'b0, 1'b0, -1, PSEQ_OFF, 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) tick();
    check_outputs("start_abort", M_CLOSED, 3'b111, 14'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    $display("[TB] start+abort in idle checked");

    // full run with an ignored start mid-LYSIS and a 10-cycle hold
    exp_q.delete();
    push_front(138);
    push_tail();
    pulse_start();
    wait_valve(M_LYSIS, "lysis_a");
    repeat (20) tick();
    pulse_start();
    repeat (20) tick();
    bus.hold = 1'b1;
    repeat (10) tick();
    bus.hold = 1'b0;
    drain("run_hold");
    $display("[TB] full run with hold done, %0d segments so far", seg_no);

    // abort in ELUTE on its 10th cycle
    push_front(128);
    push(M_ELUTE, 14'h0, 1'b1, 2'd0, 1'b0, 1'b0, 10, 12'h1AB, 2);
    push(M_CLOSED, 14'h0, 1'b1, 2'd0, 1'b0, 1'b0, 2, PSEQ_OFF, 0);
    push(M_CLOSED, 14'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1, PSEQ_OFF, 0);
    pulse_start();
    wait_valve(M_ELUTE, "elute_b");
    repeat (9) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_outputs("abort_close", M_CLOSED, 3'b111, 14'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    drain("run_abort");
    $display("[TB] abort run done, %0d segments so far", seg_no);

    // rst in the middle of the first COLLECT outlet
    push_front(128);
    push_work(M_ELUTE, 2'd0, 64, 15);
    push_settle(2'd0);
    pulse_start();
    wait_valve(M_COLLECT, "collect_c");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_outputs("rst_mid", M_CLOSED, 3'b111, 14'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drain("run_rst");
    $display("[TB] reset mid-collect done, %0d segments so far", seg_no);

    // clean full run after the reset
    push_front(128);
    push_tail();
    pulse_start();
    drain("run_clean");
    $display("[TB] clean full run done, %0d segments so far", seg_no);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1 ms, required finish");
    $fatal(1, "watchdog");
  end

endmodule
